// File: rtl/cs_loader.sv
// ============================================================================
// Module      : cs_loader
// Description : Byte-stream loader for the writable control store. Packs three
//               big-endian bytes into each control word, writes 64 words and
//               verifies a trailing XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_loader #(
  parameter int WORD_W = 23,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [6:0]        words_written
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [WORD_W-1:0]   r_wr_data;
  logic [ADDR_W-1:0]   r_addr;
  logic [6:0]          r_words;
  logic [7:0]          r_acc;
  logic [WORD_W-17:0]  r_hi;
  logic [7:0]          r_mid;
  logic                w_accept;

  assign w_accept = byte_valid && r_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_addr    <= '0;
      r_words   <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_mid     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state <= S_B0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_words <= '0;
            r_acc   <= '0;
          end
        end
        S_B0: begin
          if (w_accept) begin
            r_acc <= r_acc ^ byte_in;
            // A set top bit marks a malformed word: abort before any write.
            if (byte_in[7]) begin
              r_state <= S_ERR;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_hi    <= byte_in[WORD_W-17:0];
              r_state <= S_B1;
            end
          end
        end
        S_B1: begin
          if (w_accept) begin
            r_acc   <= r_acc ^ byte_in;
            r_mid   <= byte_in;
            r_state <= S_B2;
          end
        end
        S_B2: begin
          if (w_accept) begin
            r_acc     <= r_acc ^ byte_in;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= {r_hi, r_mid, byte_in};
            r_addr    <= r_addr + 1'b1;
            r_words   <= r_words + 7'd1;
            r_state   <= (r_addr == c_LAST_ADDR) ? S_CSUM : S_B0;
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            if (byte_in == r_acc) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready    = r_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign words_written = r_words;

endmodule

`default_nettype wire

// File: tb/tb_cs_loader.sv
// ============================================================================
// Module      : tb_cs_loader
// Description : Directed self-checking bench for cs_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cs_loader;
  localparam int WORD_W = 23;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [6:0]        words_written;

  cs_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every strobe and flags back-to-back strobes.
  logic [ADDR_W-1:0] wq_addr[$];
  logic [WORD_W-1:0] wq_data[$];
  logic prev_wr = 1'b0;
  int   dbl = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      check("ww_track", 32'(words_written), 32'(wq_addr.size()));
      if (prev_wr) dbl++;
    end
    prev_wr = wr_en;
  end

  logic [7:0] stream [0:192];

  function automatic logic [22:0] rom(input int i);
    return 23'((i * 32'h1357) & 32'h7F_FFFF);
  endfunction

  task automatic build(input bit bad_csum);
    logic [22:0] w;
    logic [7:0]  cs;
    cs = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      w = rom(i);
      stream[3*i]   = {1'b0, w[22:16]};
      stream[3*i+1] = w[15:8];
      stream[3*i+2] = w[7:0];
      cs = cs ^ stream[3*i] ^ stream[3*i+1] ^ stream[3*i+2];
    end
    stream[192] = bad_csum ? (cs ^ 8'h01) : cs;
  endtask

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    dbl = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers stream[first..] one byte per cycle; returns bytes accepted and cycles used.
  task automatic feed(input int first, input int n, input int duty, input bit poke,
                      input int budget, output int acc_n, output int cycles);
    bit acc;
    acc_n  = 0;
    cycles = 0;
    while (acc_n < n && cycles < budget) begin
      byte_in    = stream[first + acc_n];
      byte_valid = ($urandom_range(99) < duty);
      start      = poke && ($urandom_range(9) == 0);
      acc        = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) acc_n++;
      cycles++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic verify_writes(input string tag, input int n);
    check({tag, "_nwr"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(wq_addr[i]), 32'(i));
      check({tag, "_data"}, 32'(wq_data[i]), 32'(rom(i)));
    end
    check({tag, "_dbl"}, 32'(dbl), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wren"},  32'(wr_en), 32'd0);
    check({tag, "_waddr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wdata"}, 32'(wr_data), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    int acc_n, cyc;

    // Reset with start and byte_valid asserted: reset must win.
    rst_n = 1'b0; start = 1'b1; byte_valid = 1'b1; byte_in = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    check("rst_nwr", 32'(wq_addr.size()), 32'd0);
    rst_n = 1'b1; start = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;

    // Clean load with no gaps.
    build(1'b0);
    clear_mon();
    do_start();
    check("cl_busy", 32'(busy), 32'd1);
    check("cl_ready", 32'(byte_ready), 32'd1);
    feed(0, 193, 100, 1'b0, 400, acc_n, cyc);
    check("cl_acc", 32'(acc_n), 32'd193);
    check("cl_cycles", 32'(cyc), 32'd193);
    check("cl_done", 32'(done), 32'd1);
    check("cl_err", 32'(err), 32'd0);
    check("cl_ready_end", 32'(byte_ready), 32'd0);
    check("cl_busy_end", 32'(busy), 32'd0);
    check("cl_words", 32'(words_written), 32'd64);
    verify_writes("cl", 64);

    // Bad checksum: all writes land, then err.
    build(1'b1);
    clear_mon();
    do_start();
    check("bc_done_clr", 32'(done), 32'd0);
    check("bc_words_clr", 32'(words_written), 32'd0);
    feed(0, 193, 100, 1'b0, 400, acc_n, cyc);
    check("bc_acc", 32'(acc_n), 32'd193);
    check("bc_err", 32'(err), 32'd1);
    check("bc_done", 32'(done), 32'd0);
    check("bc_words", 32'(words_written), 32'd64);
    verify_writes("bc", 64);

    // Format error on byte0 of word 5.
    build(1'b0);
    stream[15] = 8'h80;
    clear_mon();
    do_start();
    check("fe_err_clr", 32'(err), 32'd0);
    feed(0, 16, 100, 1'b0, 40, acc_n, cyc);
    check("fe_acc", 32'(acc_n), 32'd16);
    check("fe_err", 32'(err), 32'd1);
    check("fe_done", 32'(done), 32'd0);
    check("fe_busy", 32'(busy), 32'd0);
    feed(16, 5, 100, 1'b0, 10, acc_n, cyc);
    check("fe_no_more", 32'(acc_n), 32'd0);
    check("fe_words", 32'(words_written), 32'd5);
    verify_writes("fe", 5);

    // Sparse byte_valid with start poked while busy.
    build(1'b0);
    clear_mon();
    do_start();
    feed(0, 193, 30, 1'b1, 3000, acc_n, cyc);
    check("bp_acc", 32'(acc_n), 32'd193);
    check("bp_done", 32'(done), 32'd1);
    check("bp_err", 32'(err), 32'd0);
    check("bp_words", 32'(words_written), 32'd64);
    verify_writes("bp", 64);

    // Reset after bytes 0 and 1 of word 10.
    clear_mon();
    do_start();
    feed(0, 32, 100, 1'b0, 40, acc_n, cyc);
    check("mr_acc", 32'(acc_n), 32'd32);
    rst_n = 1'b0;
    byte_valid = 1'b1;
    byte_in = stream[32];
    @(posedge clk); #1;
    check_reset_outs("mr");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check("mr_nwr", 32'(wq_addr.size()), 32'd10);
    check("mr_idle_ready", 32'(byte_ready), 32'd0);
    clear_mon();
    do_start();
    feed(0, 193, 100, 1'b0, 400, acc_n, cyc);
    check("mr_reload_done", 32'(done), 32'd1);
    check("mr_reload_err", 32'(err), 32'd0);
    verify_writes("mr", 64);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
